// File: rtl/timer_irq_unit.sv
// timer_irq_unit: programmable interval timer feeding the CPU i_timer input.
// A prescaler divides clk into ticks, a down-counter counts ticks and latches
// PEND on expiry. Registers are written through the CPU output-port path and
// read back combinationally.
// Build option: define TIMER_IRQ_PULSE_EN to make timer_irq a one-cycle pulse
// per expiry; when undefined timer_irq is the registered level PEND & IRQEN.
module timer_irq_unit #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [1:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          timer_irq
);

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_RELOAD   = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam logic [DW-1:0] CNT_ZERO = '0;
    localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};

    // Architectural state
    logic          ctrl_en_q,    ctrl_en_d;
    logic          ctrl_auto_q,  ctrl_auto_d;
    logic          ctrl_irqen_q, ctrl_irqen_d;
    logic [DW-1:0] prescale_q,   prescale_d;
    logic [DW-1:0] reload_q,     reload_d;
    logic [DW-1:0] count_q,      count_d;
    logic [DW-1:0] pcnt_q,       pcnt_d;
    logic          pend_q,       pend_d;
    logic          ovr_q,        ovr_d;
    logic          irq_q,        irq_d;

    // Decoded strobes
    logic wr_ctrl;
    logic wr_prescale;
    logic wr_reload;
    logic wr_status;
    logic en_rise;
    logic tick;
    logic expiry;

    // Write decode, tick generation and expiry detection
    always_comb begin
        wr_ctrl     = we_i && (wr_addr == ADDR_CTRL);
        wr_prescale = we_i && (wr_addr == ADDR_PRESCALE);
        wr_reload   = we_i && (wr_addr == ADDR_RELOAD);
        wr_status   = we_i && (wr_addr == ADDR_STATUS);
        en_rise     = wr_ctrl && wr_data[0] && !ctrl_en_q;
        // A RELOAD write restarts the period, so a coincident tick is dropped.
        tick        = ctrl_en_q && (pcnt_q == CNT_ZERO) && !wr_reload;
        expiry      = tick && (count_q == CNT_ONE);
    end

    // CTRL next state: software write, or hardware EN clear on one-shot expiry
    always_comb begin
        ctrl_en_d    = ctrl_en_q;
        ctrl_auto_d  = ctrl_auto_q;
        ctrl_irqen_d = ctrl_irqen_q;
        if (wr_ctrl) begin
            ctrl_en_d    = wr_data[0];
            ctrl_auto_d  = wr_data[1];
            ctrl_irqen_d = wr_data[2];
        end else if (expiry && !ctrl_auto_q) begin
            ctrl_en_d = 1'b0;
        end
    end

    // PRESCALE and RELOAD register writes
    always_comb begin
        prescale_d = prescale_q;
        reload_d   = reload_q;
        if (wr_prescale) begin
            prescale_d = wr_data;
        end
        if (wr_reload) begin
            reload_d = wr_data;
        end
    end

    // Prescaler: restart on RELOAD write or enable, else free-run while enabled
    always_comb begin
        pcnt_d = pcnt_q;
        if (wr_reload || en_rise) begin
            pcnt_d = prescale_q;
        end else if (ctrl_en_q) begin
            if (pcnt_q == CNT_ZERO) begin
                pcnt_d = prescale_q;
            end else begin
                pcnt_d = pcnt_q - CNT_ONE;
            end
        end
    end

    // Down-counter: RELOAD write wins, then enable preload, then tick handling
    always_comb begin
        count_d = count_q;
        if (wr_reload) begin
            count_d = wr_data;
        end else if (en_rise && (count_q == CNT_ZERO)) begin
            count_d = reload_q;
        end else if (tick) begin
            if (count_q == CNT_ONE) begin
                count_d = ctrl_auto_q ? reload_q : CNT_ZERO;
            end else if (count_q != CNT_ZERO) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Status flags: expiry set has priority over a coincident W1C clear
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (wr_status && wr_data[0]) begin
            pend_d = 1'b0;
        end
        if (wr_status && wr_data[1]) begin
            ovr_d = 1'b0;
        end
        if (expiry) begin
            pend_d = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Interrupt output next state
    always_comb begin
`ifdef TIMER_IRQ_PULSE_EN
        irq_d = expiry && ctrl_irqen_d;
`else
        irq_d = pend_d && ctrl_irqen_d;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en_q    <= 1'b0;
            ctrl_auto_q  <= 1'b0;
            ctrl_irqen_q <= 1'b0;
            prescale_q   <= '0;
            reload_q     <= '0;
            count_q      <= '0;
            pcnt_q       <= '0;
            pend_q       <= 1'b0;
            ovr_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_en_q    <= ctrl_en_d;
            ctrl_auto_q  <= ctrl_auto_d;
            ctrl_irqen_q <= ctrl_irqen_d;
            prescale_q   <= prescale_d;
            reload_q     <= reload_d;
            count_q      <= count_d;
            pcnt_q       <= pcnt_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            irq_q        <= irq_d;
        end
    end

    assign timer_irq = irq_q;

    // Combinational read-back mux
    always_comb begin
        rd_data = '0;
        unique case (rd_addr)
            ADDR_CTRL: begin
                rd_data[0] = ctrl_en_q;
                rd_data[1] = ctrl_auto_q;
                rd_data[2] = ctrl_irqen_q;
            end
            ADDR_PRESCALE: rd_data = prescale_q;
            ADDR_RELOAD:   rd_data = count_q;
            ADDR_STATUS: begin
                rd_data[0] = pend_q;
                rd_data[1] = ovr_q;
            end
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed self-checking bench for timer_irq_unit. Clock period 10 ns; inputs
// are driven and outputs sampled 1 ns after the rising edge.
module tb_timer_irq_unit;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we_i = 1'b0;
    logic [1:0]    wr_addr = 2'd0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    rd_addr = 2'd0;
    logic [DW-1:0] rd_data;
    logic          timer_irq;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_irq_unit #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we_i),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .timer_irq (timer_irq)
    );

    // One register write, taking effect on the next rising edge
    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        we_i = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    // Advance n rising edges (n >= 1), ending 1 ns after the last one
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [DW-1:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        reset = 1'b0;
        #2;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            n_cmp++;
            if (v !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got=%h exp=00", a, v);
            end
        end
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", timer_irq);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycles(1);
    endtask

    // PRESCALE=3, RELOAD=5: expiries every 20 cycles after the enabling edge
    task automatic test_auto_reload();
        logic [DW-1:0] v;
        wr(2'd1, 8'd3);
        wr(2'd2, 8'd5);
        wr(2'd0, 8'h07);
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'd5) begin
            n_fail++;
            $display("FAIL auto_count_start got=%0d exp=5", v);
        end
        cycles(4);
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'd4) begin
            n_fail++;
            $display("FAIL auto_count_first_tick got=%0d exp=4", v);
        end
        cycles(15);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h00 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_before_expiry status=%h irq=%b exp 00/0", v, timer_irq);
        end
        cycles(1);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h01 || timer_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_first_expiry status=%h irq=%b exp 01/1", v, timer_irq);
        end
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'd5) begin
            n_fail++;
            $display("FAIL auto_count_reloaded got=%0d exp=5", v);
        end
        cycles(1);
        n_cmp++;
`ifdef TIMER_IRQ_PULSE_EN
        if (timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_irq_after_pulse got=%b exp=0", timer_irq);
        end
`else
        if (timer_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_irq_level_hold got=%b exp=1", timer_irq);
        end
`endif
    endtask

    // Continue from auto-reload: second expiry at edge 40 sets OVR
    task automatic test_overflow();
        logic [DW-1:0] v;
        cycles(18);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL ovr_before_second status=%h exp=01", v);
        end
        cycles(1);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h03 || timer_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_second_expiry status=%h irq=%b exp 03/1", v, timer_irq);
        end
        wr(2'd3, 8'h03);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h00 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear status=%h irq=%b exp 00/0", v, timer_irq);
        end
        wr(2'd0, 8'h00);
    endtask

    // PRESCALE=0, RELOAD=4, CTRL=EN|IRQEN: single expiry then EN self-clears
    task automatic test_one_shot();
        logic [DW-1:0] v;
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd4);
        wr(2'd0, 8'h05);
        cycles(3);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL oneshot_early status=%h exp=00", v);
        end
        cycles(1);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h01 || timer_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_expiry status=%h irq=%b exp 01/1", v, timer_irq);
        end
        rd(2'd0, v);
        n_cmp++;
        if (v !== 8'h04) begin
            n_fail++;
            $display("FAIL oneshot_ctrl got=%h exp=04", v);
        end
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL oneshot_count got=%h exp=00", v);
        end
        cycles(50);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL oneshot_no_refire status=%h exp=01", v);
        end
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL oneshot_count_idle got=%h exp=00", v);
        end
        wr(2'd3, 8'h03);
    endtask

    // RELOAD=2, PRESCALE=0, AUTO: expiries every 2 cycles; clear collides with one
    task automatic test_collision_and_mask();
        logic [DW-1:0] v;
        wr(2'd2, 8'd2);
        wr(2'd0, 8'h03);
        cycles(2);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h01 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_first status=%h irq=%b exp 01/0", v, timer_irq);
        end
        cycles(1);
        wr(2'd3, 8'h03);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h03) begin
            n_fail++;
            $display("FAIL coll_set_wins status=%h exp=03", v);
        end
        wr(2'd0, 8'h07);
        n_cmp++;
`ifdef TIMER_IRQ_PULSE_EN
        if (timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_enable_no_expiry got=%b exp=0", timer_irq);
        end
`else
        if (timer_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_enable_level got=%b exp=1", timer_irq);
        end
`endif
        wr(2'd0, 8'h03);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h03 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_drop status=%h irq=%b exp 03/0", v, timer_irq);
        end
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h03);
    endtask

    // RELOAD=0 never fires; async reset mid-count clears everything
    task automatic test_zero_and_reset();
        logic [DW-1:0] v;
        wr(2'd2, 8'd0);
        wr(2'd0, 8'h05);
        cycles(100);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h00 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_fire status=%h irq=%b exp 00/0", v, timer_irq);
        end
        wr(2'd0, 8'h00);
        wr(2'd1, 8'd5);
        wr(2'd2, 8'd3);
        wr(2'd0, 8'h07);
        rd(2'd2, v);
        n_cmp++;
        if (v !== 8'd3) begin
            n_fail++;
            $display("FAIL reset_pre_count got=%0d exp=3", v);
        end
        reset = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            n_cmp++;
            if (v !== 8'h00) begin
                n_fail++;
                $display("FAIL async_reset_read addr=%0d got=%h exp=00", a, v);
            end
        end
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_irq got=%b exp=0", timer_irq);
        end
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_overflow();
        test_one_shot();
        test_collision_and_mask();
        test_zero_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq_unit.md
# timer_irq_unit

Programmable interval timer that drives the CPU's `i_timer` interrupt input and is configured by the CPU through its output-port write path (`we_o`, `hilo_out`, `out_pN`). A prescaler divides `clk` into ticks. A down-counter counts ticks and latches an interrupt-pending flag on expiry. Register contents are read back combinationally onto one CPU input port, selected by `hilo_in`.

## Interface
Parameters:
- `DW`, default 8: width of the data bus, PRESCALE, RELOAD and COUNT registers.

Ports:
- `clk` input, 1 bit: single system clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `we_i` input, 1 bit: register write strobe, from CPU `we_o`.
- `wr_addr` input, 2 bits: write register select, from CPU `hilo_out`.
- `wr_data` input, DW bits: write data, from the selected CPU `out_pN`.
- `rd_addr` input, 2 bits: read register select, from CPU `hilo_in`.
- `rd_data` output, DW bits: combinational read-back, to a CPU `in_pN`.
- `timer_irq` output, 1 bit: interrupt request, to CPU `i_timer`; driven directly by a flop.

## Operation
Register map:
- **Address 0, CTRL**
  - Write: bit0 EN, bit1 AUTO, bit2 IRQEN; upper bits are ignored.
  - Read: returns the register value.
- **Address 1, PRESCALE**
  - Write: sets the prescale value.
  - Read: returns the register value.
- **Address 2, RELOAD / COUNT**
  - Write: sets RELOAD, loads COUNT with `wr_data`, and loads the prescaler counter with PRESCALE.
  - Read: returns the live COUNT.
- **Address 3, STATUS**
  - Write: write-1-to-clear; bit0 PEND, bit1 OVR.
  - Read: returns {0…, OVR, PEND}.

Prescaler:
- Internal counter PCNT.
- While EN=1: if PCNT==0, assert tick for that cycle and reload PCNT with PRESCALE; otherwise PCNT decrements.
- While EN=0: PCNT holds and no tick is generated.
- Tick period is PRESCALE+1 cycles.

Counter, on each tick:
- **COUNT==0:** nothing happens. RELOAD=0 therefore never fires.
- **COUNT==1 (expiry):**
  - Set PEND.
  - Set OVR if PEND was already 1.
  - If AUTO=1, COUNT becomes RELOAD.
  - If AUTO=0, COUNT becomes 0 and hardware clears EN.
- **COUNT>1:** COUNT decrements.

Enable:
- A CTRL write that changes EN from 0 to 1 loads PCNT with PRESCALE.
- If COUNT==0 at that write, it also loads COUNT with RELOAD.

Interrupt:
- `timer_irq` follows PEND & IRQEN; see Configuration for the exact form.
- Clearing IRQEN masks `timer_irq` but does not clear PEND.

Boundary and priority rules:
- An expiry and a STATUS clear in the same cycle: the set wins, so PEND stays 1 and OVR is set if PEND was 1.
- A RELOAD write in the same cycle as a tick: the write wins and that tick is discarded.
- A CTRL write with EN=0 in the same cycle as an expiry: EN ends at 0, and the PEND and OVR updates still occur.
- Writing PRESCALE while running takes effect at the next PCNT reload.

## Timing
- Reset values: CTRL=0, PRESCALE=0, RELOAD=0, COUNT=0, PCNT=0, PEND=0, OVR=0, `timer_irq`=0, `rd_data`=0 (rd_addr=0 selects CTRL=0).
- Writes take effect at the rising edge on which `we_i`=1.
- `rd_data` has zero-cycle latency: it reflects register state after the last edge.
- With auto-reload, the first expiry occurs (PRESCALE+1)·RELOAD cycles after the enabling edge. Subsequent expiries follow at the same period.
- PEND and `timer_irq` rise at the edge that ends the expiry tick cycle.
- Asserting `reset` mid-count returns all state to reset values immediately, without waiting for a clock edge.

## Configuration
- **`TIMER_IRQ_PULSE_EN` defined:** `timer_irq` is a one-cycle pulse.
  - It is high for exactly the cycle after each expiry where IRQEN=1.
  - PEND still latches and needs a W1C clear.
- **`TIMER_IRQ_PULSE_EN` undefined:** `timer_irq` is a level equal to the registered PEND & IRQEN, held until PEND is cleared or IRQEN is dropped.

## Test plan
- **Auto-reload period:** reset, write PRESCALE=3, RELOAD=5, CTRL=0b111 → first `timer_irq` 20 cycles after the CTRL write edge. In level mode it stays high; in pulse mode it is high for 1 cycle and repeats every 20 cycles.
- **Overflow:** keep the previous setup and never clear → after the second expiry, STATUS reads 0b11. Write STATUS=0b11 → reads 0, and in level mode `timer_irq` falls at the next edge.
- **One-shot:** PRESCALE=0, RELOAD=4, CTRL=0b101 → PEND set after 4 cycles. CTRL then reads 0b100, COUNT reads 0, and no further expiries occur over 50 cycles.
- **Clear/expiry collision:** with PEND=1, issue a STATUS clear in the expiry cycle → PEND remains 1 and OVR=1.
- **Zero and reset:** RELOAD=0 with EN=1 → no interrupt over 100 cycles. Separately, assert `reset` mid-count with COUNT=3 → all reads return 0 and `timer_irq`=0 with no clock edge needed.
